// File: rtl/car_motion_sequencer.sv
// Elevator car motion sequencer: steps the car one floor per TRAVEL_TICKS timebase
// ticks toward an accepted target, then holds the door open for DOOR_TICKS ticks.
module car_motion_sequencer #(
   parameter int FLOORS       = 8,
   parameter int FLOOR_W      = 3,
   parameter int TRAVEL_TICKS = 4,
   parameter int DOOR_TICKS   = 6,
   parameter int TICK_W       = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               slow_clk,
   input  logic               req_valid,
   input  logic [FLOOR_W-1:0] req_floor,
   output logic               req_ready,
   output logic [FLOOR_W-1:0] cur_floor,
   output logic               moving_up,
   output logic               moving_down,
   output logic               door_open,
   output logic               arrive,
   output logic               busy,
   output logic [1:0]         state_dbg
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MOVE = 2'd1,
      ST_DOOR = 2'd2
   } state_t;

   localparam logic [FLOOR_W:0]  FLOORS_X    = (FLOOR_W+1)'(FLOORS);
   localparam logic [TICK_W-1:0] TRAVEL_LAST = TICK_W'(TRAVEL_TICKS - 1);
   localparam logic [TICK_W-1:0] DOOR_LAST   = TICK_W'(DOOR_TICKS - 1);

   state_t             state_q, state_d;
   logic [FLOOR_W-1:0] floor_q, floor_d;
   logic [FLOOR_W-1:0] target_q, target_d;
   logic [FLOOR_W-1:0] step_floor;
   logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
   logic               slow_q, tick;
   logic               up_q, up_d, down_q, down_d;
   logic               door_q, door_d, arrive_q, arrive_d, busy_q, busy_d;

   // One tick per rising edge of the divider output, however long it stays high.
   assign tick       = slow_clk & ~slow_q;
   assign step_floor = up_q ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         floor_q    <= '0;
         target_q   <= '0;
         tick_cnt_q <= '0;
         slow_q     <= 1'b0;
         up_q       <= 1'b0;
         down_q     <= 1'b0;
         door_q     <= 1'b0;
         arrive_q   <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         floor_q    <= floor_d;
         target_q   <= target_d;
         tick_cnt_q <= tick_cnt_d;
         slow_q     <= slow_clk;
         up_q       <= up_d;
         down_q     <= down_d;
         door_q     <= door_d;
         arrive_q   <= arrive_d;
         busy_q     <= busy_d;
      end
   end

   // Handshake: a request transfers on any clk edge where req_valid && req_ready;
   // req_ready is high only in IDLE and upstream holds the request stable until then.
   always_comb begin
      state_d    = state_q;
      floor_d    = floor_q;
      target_d   = target_q;
      tick_cnt_d = tick_cnt_q;
      up_d       = up_q;
      down_d     = down_q;
      door_d     = door_q;
      arrive_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_valid && ({1'b0, req_floor} < FLOORS_X)) begin
               target_d   = req_floor;
               tick_cnt_d = '0;
               if (req_floor == floor_q) begin
                  state_d  = ST_DOOR;
                  door_d   = 1'b1;
                  arrive_d = 1'b1;
               end else begin
                  state_d = ST_MOVE;
                  up_d    = (req_floor > floor_q);
                  down_d  = (req_floor < floor_q);
               end
            end
         end
         ST_MOVE: begin
            if (tick) begin
               if (tick_cnt_q == TRAVEL_LAST) begin
                  tick_cnt_d = '0;
                  floor_d    = step_floor;
                  if (step_floor == target_q) begin
                     state_d  = ST_DOOR;
                     up_d     = 1'b0;
                     down_d   = 1'b0;
                     door_d   = 1'b1;
                     arrive_d = 1'b1;
                  end
               end else begin
                  tick_cnt_d = tick_cnt_q + TICK_W'(1);
               end
            end
         end
         ST_DOOR: begin
            if (tick) begin
               if (tick_cnt_q == DOOR_LAST) begin
                  state_d    = ST_IDLE;
                  door_d     = 1'b0;
                  tick_cnt_d = '0;
               end else begin
                  tick_cnt_d = tick_cnt_q + TICK_W'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   assign req_ready   = (state_q == ST_IDLE);
   assign cur_floor   = floor_q;
   assign moving_up   = up_q;
   assign moving_down = down_q;
   assign door_open   = door_q;
   assign arrive      = arrive_q;
   assign busy        = busy_q;
   assign state_dbg   = state_q;

endmodule

// File: tb/tb_car_motion_sequencer.sv
// Scoreboarded bench for car_motion_sequencer: requests push their expected output
// events (values plus tick/cycle spacing); a negedge monitor pops and compares.
module tb_car_motion_sequencer;

   localparam int FW = 4;
   localparam int W  = 21;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          slow_clk = 1'b0;
   logic          req_valid = 1'b0;
   logic [FW-1:0] req_floor = '0;
   logic          req_ready;
   logic [FW-1:0] cur_floor;
   logic          moving_up, moving_down, door_open, arrive, busy;
   logic [1:0]    state_dbg;

   car_motion_sequencer #(
      .FLOORS(8), .FLOOR_W(FW), .TRAVEL_TICKS(4), .DOOR_TICKS(6), .TICK_W(8)
   ) dut (
      .clk(clk), .rst(rst), .slow_clk(slow_clk),
      .req_valid(req_valid), .req_floor(req_floor), .req_ready(req_ready),
      .cur_floor(cur_floor), .moving_up(moving_up), .moving_down(moving_down),
      .door_open(door_open), .arrive(arrive), .busy(busy), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   // slow_clk: period 8 clk, changes on negedges; freeze holds its current level.
   logic freeze = 1'b0;
   initial begin : slow_gen
      int ph;
      ph = 0;
      forever begin
         @(negedge clk);
         if (!freeze) begin
            ph++;
            if (ph == 4) begin
               ph = 0;
               slow_clk = ~slow_clk;
            end
         end
      end
   end

   logic        slow_prev = 1'b0;
   int unsigned tick_total = 0;
   always @(posedge clk) begin
      slow_prev <= slow_clk;
      if (slow_clk && !slow_prev) tick_total <= tick_total + 1;
   end

   // Scoreboard entry: {chk_ticks, chk_cycles, keep_tick_mark, spacing[7:0], outputs[9:0]}
   logic [W-1:0] exp_q[$];
   int           n_cmp = 0;
   int           n_bad = 0;
   int           model_floor = 0;
   logic         mon_en = 1'b0;
   logic [9:0]   prev_o;
   int unsigned  tick_mark;
   int           gap;

   function automatic logic [9:0] mk(int f, bit u, bit d, bit o, bit a, bit b, bit r);
      logic [FW-1:0] fv;
      fv = FW'(f);
      return {fv, u, d, o, a, b, r};
   endfunction

   function automatic logic [9:0] obs();
      return {cur_floor, moving_up, moving_down, door_open, arrive, busy, req_ready};
   endfunction

   task automatic push(input logic [9:0] o, input bit ct, input bit cc, input bit keep, input int val);
      logic [7:0] v;
      v = 8'(val);
      exp_q.push_back({ct, cc, keep, v, o});
   endtask

   // Expected event sequence for one request, from the bench's own floor model.
   task automatic push_request(input int t, input int acc_gap);
      int  f;
      bit  up;
      if (t >= 8) return;
      if (t == model_floor) begin
         push(mk(t, 0, 0, 1, 1, 1, 0), 0, acc_gap != 0, 0, acc_gap);
      end else begin
         up = (t > model_floor);
         push(mk(model_floor, up, !up, 0, 0, 1, 0), 0, acc_gap != 0, 0, acc_gap);
         f = model_floor;
         while (f != t) begin
            f = up ? f + 1 : f - 1;
            if (f != t) push(mk(f, up, !up, 0, 0, 1, 0), 1, 0, 0, 4);
            else        push(mk(t, 0, 0, 1, 1, 1, 0), 1, 0, 0, 4);
         end
      end
      push(mk(t, 0, 0, 1, 0, 1, 0), 0, 1, 1, 1);
      push(mk(t, 0, 0, 0, 0, 0, 1), 1, 0, 0, 6);
      model_floor = t;
   endtask

   always @(negedge clk) begin : monitor
      logic [9:0]   o_now;
      logic [W-1:0] e;
      int           dt;
      if (mon_en) begin
         gap = gap + 1;
         o_now = obs();
         if (o_now != prev_o) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_event: got %b, required no output change", o_now);
            end else begin
               e = exp_q.pop_front();
               if (o_now != e[9:0]) begin
                  n_bad++;
                  $display("FAIL event_outputs (floor,up,dn,door,arr,busy,rdy): got %b required %b", o_now, e[9:0]);
               end
               dt = int'(tick_total - tick_mark);
               if (e[20]) begin
                  n_cmp++;
                  if (dt != int'(e[17:10])) begin
                     n_bad++;
                     $display("FAIL event_ticks at %b: got %0d ticks required %0d", o_now, dt, e[17:10]);
                  end
               end
               if (e[19]) begin
                  n_cmp++;
                  if (gap != int'(e[17:10])) begin
                     n_bad++;
                     $display("FAIL event_cycles at %b: got %0d cycles required %0d", o_now, gap, e[17:10]);
                  end
               end
               if (!e[18]) tick_mark = tick_total;
            end
            gap = 0;
            prev_o = o_now;
         end
      end
   end

   task automatic check(input string name, input int got, input int req);
      n_cmp++;
      if (got != req) begin
         n_bad++;
         $display("FAIL %s: got %0d required %0d", name, got, req);
      end
   endtask

   task automatic issue(input int t);
      @(negedge clk);
      req_floor = FW'(t);
      req_valid = 1'b1;
   endtask

   task automatic wait_accept();
      int n;
      n = 0;
      while (!req_ready && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("accept_timeout", int'(req_ready), 1);
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (!req_ready && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("idle_timeout", int'(req_ready), 1);
   endtask

   task automatic send(input int t);
      issue(t);
      wait_accept();
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_cur_floor", int'(cur_floor), 0);
      check("rst_req_ready", int'(req_ready), 1);
      check("rst_busy", int'(busy), 0);
      check("rst_motion_door_arrive", int'({moving_up, moving_down, door_open, arrive}), 0);
      check("rst_state", int'(state_dbg), 0);
      prev_o    = obs();
      tick_mark = tick_total;
      gap       = 0;
      mon_en    = 1'b1;

      // upward, upward, downward, same floor
      push_request(3, 0); send(3);
      push_request(5, 0); send(5);
      push_request(2, 0); send(2);
      push_request(2, 0); send(2);

      // out-of-range floor is consumed without any output change
      wait_idle();
      send(9);
      repeat (10) @(negedge clk);
      check("oor_cur_floor", int'(cur_floor), 2);
      check("oor_ready", int'(req_ready), 1);
      check("oor_busy", int'(busy), 0);

      // request held valid during a move is taken in the first IDLE cycle
      push_request(7, 0); send(7);
      push_request(0, 1); issue(0);
      repeat (20) @(negedge clk);
      check("held_ready_low", int'(req_ready), 0);
      check("held_moving_up", int'(moving_up), 1);
      wait_accept();

      // slow_clk stuck high for 100 cycles gives a single tick
      push_request(4, 0); send(4);
      @(posedge slow_clk);
      #1 freeze = 1'b1;
      repeat (100) @(negedge clk);
      check("stuck_high_floor", int'(cur_floor), 0);
      freeze = 1'b0;

      // acceptance on the same edge as a tick: that tick is not counted
      wait_idle();
      push_request(1, 0);
      @(posedge slow_clk);
      #1;
      req_floor = FW'(1);
      req_valid = 1'b1;
      wait_accept();

      // reset at floor 2 on the way to 6, two ticks into the next floor
      wait_idle();
      push(mk(1, 1, 0, 0, 0, 1, 0), 0, 0, 0, 0);
      push(mk(2, 1, 0, 0, 0, 1, 0), 1, 0, 0, 4);
      push(mk(0, 0, 0, 0, 0, 0, 1), 0, 0, 0, 0);
      model_floor = 0;
      send(6);
      begin
         int n;
         n = 0;
         while (cur_floor != FW'(2) && n < 500) begin
            @(negedge clk);
            n++;
         end
      end
      check("mid_reach_floor2", int'(cur_floor), 2);
      @(posedge slow_clk);
      @(posedge slow_clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("midrst_cur_floor", int'(cur_floor), 0);
      check("midrst_moving_up", int'(moving_up), 0);
      check("midrst_state", int'(state_dbg), 0);
      check("midrst_arrive", int'(arrive), 0);
      repeat (150) @(negedge clk);

      begin
         int n;
         n = 0;
         while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
         end
      end
      check("events_outstanding", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      repeat (60000) @(posedge clk);
      $display("FAIL watchdog: got no completion within 60000 cycles, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
